// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: free-running DrawX/DrawY counters with registered blank,
// line/frame pulses and hs/vs sync delayed SYNC_DELAY clocks to match the mapper pipeline.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at the total still compares correctly
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       hs_raw_q, hs_raw_d;
  logic       vs_raw_q, vs_raw_d;
  logic       h_vis, v_vis, h_sync_win, v_sync_win;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Every registered output is a function of the counter value being loaded,
  // so it lines up with DrawX/DrawY on the same edge.
  always_comb begin
    h_vis         = {1'b0, x_d} < H_VIS;
    v_vis         = {1'b0, y_d} < V_VIS;
    h_sync_win    = ({1'b0, x_d} >= H_SYNC_BEG) && ({1'b0, x_d} < H_SYNC_END);
    v_sync_win    = ({1'b0, y_d} >= V_SYNC_BEG) && ({1'b0, y_d} < V_SYNC_END);
    blank_d       = h_vis && v_vis;
    hs_raw_d      = h_sync_win ? SYNC_POL : ~SYNC_POL;
    vs_raw_d      = v_sync_win ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      hs_raw_q      <= ~SYNC_POL;
      vs_raw_q      <= ~SYNC_POL;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs = hs_raw_q;
    assign vs = vs_raw_q;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_sr_q, hs_sr_d;
    logic [SYNC_DELAY-1:0] vs_sr_q, vs_sr_d;

    always_comb begin
      hs_sr_d[0] = hs_raw_q;
      vs_sr_d[0] = vs_raw_q;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_sr_d[i] = hs_sr_q[i-1];
        vs_sr_d[i] = vs_sr_q[i-1];
      end
    end

    // Clearing every stage keeps a pulse caught mid-pipeline from leaking out after reset.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        hs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
        vs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
      end else begin
        hs_sr_q <= hs_sr_d;
        vs_sr_q <= vs_sr_d;
      end
    end

    assign hs = hs_sr_q[SYNC_DELAY-1];
    assign vs = vs_sr_q[SYNC_DELAY-1];
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing with SYNC_DELAY 2 and 0, plus a reduced-timing instance for whole frames.
module tb_vga_timing_gen;

  logic clk;
  logic rst0, rst1, rst2;

  logic [9:0] dx0, dy0, dx1, dy1, dx2, dy2;
  logic bl0, hs0, vs0, ls0, fs0;
  logic bl1, hs1, vs1, ls1, fs1;
  logic bl2, hs2, vs2, ls2, fs2;

  int n_cmp;
  int n_bad;

  logic [9:0] ex, ey;
  logic [9:0] sx, sy;

  vga_timing_gen #(.SYNC_DELAY(2)) dut0 (
    .vga_clk(clk), .reset(rst0), .DrawX(dx0), .DrawY(dy0), .blank(bl0),
    .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut1 (
    .vga_clk(clk), .reset(rst1), .DrawX(dx1), .DrawY(dy1), .blank(bl1),
    .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1)
  );

  // 16 x 11 totals: x sync 10..12, y sync 7..8, 176 clocks per frame
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .SYNC_DELAY(1)
  ) dut2 (
    .vga_clk(clk), .reset(rst2), .DrawX(dx2), .DrawY(dy2), .blank(bl2),
    .hs(hs2), .vs(vs2), .line_start(ls2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  task automatic step0();
    @(posedge clk);
    @(negedge clk);
    if (ex == 10'd799) begin
      ex = '0;
      ey = (ey == 10'd524) ? 10'd0 : ey + 10'd1;
    end else begin
      ex = ex + 10'd1;
    end
  endtask

  task automatic step2();
    @(posedge clk);
    @(negedge clk);
    if (sx == 10'd15) begin
      sx = '0;
      sy = (sy == 10'd10) ? 10'd0 : sy + 10'd1;
    end else begin
      sx = sx + 10'd1;
    end
  endtask

  task automatic test_reset();
    logic [24:0] got, want;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got  = {dx0, dy0, bl0, hs0, vs0, ls0, fs0};
    want = {10'd0, 10'd0, 5'b11111};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_state_d2: got %h expected %h", got, want);
    end
    got = {dx1, dy1, bl1, hs1, vs1, ls1, fs1};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_state_d0: got %h expected %h", got, want);
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    ex = '0; ey = '0;
    step0();
    got  = {dx0, dy0, bl0, hs0, vs0, ls0, fs0};
    want = {10'd1, 10'd0, 5'b11100};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL first_edge: got %h expected %h", got, want);
    end
  endtask

  task automatic test_hs_window();
    int pos_err = 0, lo0 = 0, lo1 = 0, first0 = -1, first1 = -1, last1 = -1, bl_cnt = 0;
    logic [1:0] bl_edge = 2'bxx;
    for (int i = 0; i < 800; i++) begin
      step0();
      if (dx0 !== ex || dy0 !== ey || dx1 !== ex || dy1 !== ey) pos_err++;
      if (hs1 === 1'b0) begin
        lo1++;
        if (first1 < 0) first1 = int'(ex);
        last1 = int'(ex);
      end
      if (hs0 === 1'b0) begin
        lo0++;
        if (first0 < 0) first0 = int'(ex);
      end
      if (bl0 === 1'b1) bl_cnt++;
      if (ex == 10'd639) bl_edge[1] = bl0;
      if (ex == 10'd640) bl_edge[0] = bl0;
    end
    n_cmp++;
    if (pos_err !== 0) begin
      n_bad++; $display("FAIL counter_track: got %0d bad samples expected 0", pos_err);
    end
    n_cmp++;
    if (lo1 !== 96) begin
      n_bad++; $display("FAIL hs_nodelay_width: got %0d expected 96", lo1);
    end
    n_cmp++;
    if (first1 !== 656 || last1 !== 751) begin
      n_bad++; $display("FAIL hs_nodelay_window: got %0d..%0d expected 656..751", first1, last1);
    end
    n_cmp++;
    if (lo0 !== 96 || first0 !== 658) begin
      n_bad++; $display("FAIL hs_delay2: got width %0d first %0d expected 96 at 658", lo0, first0);
    end
    n_cmp++;
    if (bl_cnt !== 640 || bl_edge !== 2'b10) begin
      n_bad++; $display("FAIL blank_line: got %0d edge %b expected 640 edge 10", bl_cnt, bl_edge);
    end
  endtask

  task automatic test_line_wrap();
    int ls_cnt = 0;
    for (int i = 0; i < 10000 && !(ex == 10'd799 && ey == 10'd5); i++) begin
      step0();
      if (ls0 === 1'b1) ls_cnt++;
    end
    n_cmp++;
    if (ls_cnt !== 4) begin
      n_bad++; $display("FAIL line_start_count: got %0d expected 4", ls_cnt);
    end
    n_cmp++;
    if ({dx0, dy0, ls0} !== {10'd799, 10'd5, 1'b0}) begin
      n_bad++; $display("FAIL pre_wrap: got x=%0d y=%0d ls=%b expected 799 5 0", dx0, dy0, ls0);
    end
    step0();
    n_cmp++;
    if ({dx0, dy0, ls0, fs0} !== {10'd0, 10'd6, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b expected 0 6 1 0", dx0, dy0, ls0, fs0);
    end
    step0();
    n_cmp++;
    if ({dx0, ls0} !== {10'd1, 1'b0}) begin
      n_bad++; $display("FAIL line_start_width: got x=%0d ls=%b expected 1 0", dx0, ls0);
    end
  endtask

  task automatic test_mid_reset();
    int hs_lo = 0, fs_cnt = 0;
    // reset lands while the delayed hs pipeline holds a sync pulse
    for (int i = 0; i < 2000 && ex != 10'd657; i++) step0();
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    ex = '0; ey = '0;
    n_cmp++;
    if ({dx0, dy0, fs0, hs0, vs0} !== {10'd0, 10'd0, 3'b111}) begin
      n_bad++; $display("FAIL mid_reset_state: got x=%0d y=%0d fs=%b hs=%b vs=%b expected 0 0 1 1 1",
                        dx0, dy0, fs0, hs0, vs0);
    end
    for (int i = 0; i < 4; i++) begin
      step0();
      if (hs0 !== 1'b1) hs_lo++;
      if (fs0 === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (hs_lo !== 0) begin
      n_bad++; $display("FAIL stale_hs: got %0d low samples expected 0", hs_lo);
    end
    n_cmp++;
    if (fs_cnt !== 0 || dx0 !== 10'd4) begin
      n_bad++; $display("FAIL post_reset_run: got fs=%0d x=%0d expected 0 4", fs_cnt, dx0);
    end
  endtask

  task automatic test_small_frame();
    int pos_err = 0, bl_cnt = 0, ls_cnt = 0, fs_cnt = 0, hs_lo = 0, vs_lo = 0;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dx2, dy2, bl2, hs2, vs2, ls2, fs2} !== {10'd0, 10'd0, 5'b11111}) begin
      n_bad++; $display("FAIL small_reset: got x=%0d y=%0d hs=%b vs=%b expected 0 0 1 1", dx2, dy2, hs2, vs2);
    end
    rst2 = 1'b0;
    sx = '0; sy = '0;
    for (int i = 0; i < 176; i++) begin
      step2();
      if (dx2 !== sx || dy2 !== sy) pos_err++;
      if (bl2 === 1'b1) bl_cnt++;
      if (ls2 === 1'b1) ls_cnt++;
      if (fs2 === 1'b1) fs_cnt++;
      if (hs2 === 1'b0) hs_lo++;
      if (vs2 === 1'b0) vs_lo++;
    end
    n_cmp++;
    if (pos_err !== 0 || {dx2, dy2, fs2} !== {10'd0, 10'd0, 1'b1}) begin
      n_bad++; $display("FAIL frame_wrap: got %0d bad, end x=%0d y=%0d fs=%b expected 0 0 0 1",
                        pos_err, dx2, dy2, fs2);
    end
    n_cmp++;
    if (bl_cnt !== 48) begin
      n_bad++; $display("FAIL frame_blank: got %0d expected 48", bl_cnt);
    end
    n_cmp++;
    if (ls_cnt !== 11 || fs_cnt !== 1) begin
      n_bad++; $display("FAIL frame_pulses: got ls=%0d fs=%0d expected 11 1", ls_cnt, fs_cnt);
    end
    n_cmp++;
    if (hs_lo !== 33 || vs_lo !== 32) begin
      n_bad++; $display("FAIL frame_sync: got hs_low=%0d vs_low=%0d expected 33 32", hs_lo, vs_lo);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_hs_window();
    test_line_wrap();
    test_mid_reset();
    test_small_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
